// File: rtl/alu_nbit_seq_if.sv
// alu_nbit_seq_if: request/response bundle for the sequential N-bit ALU.
//   master : drives start, a, b, ainvert, binvert, operation, mul_mode;
//            observes result, result_hi, carry_out, overflow, zero, busy, done.
//   slave  : the ALU side (directions mirrored).
interface alu_nbit_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ainvert;
  logic             binvert;
  logic [1:0]       operation;
  logic             mul_mode;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, ainvert, binvert, operation, mul_mode,
    input  result, result_hi, carry_out, overflow, zero, busy, done
  );

  modport slave (
    input  start, a, b, ainvert, binvert, operation, mul_mode,
    output result, result_hi, carry_out, overflow, zero, busy, done
  );
endinterface

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: WIDTH-bit registered ALU (AND/OR/ADD/SLT with operand
// inversion) plus a WIDTH-cycle unsigned shift-add multiplier.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : alu_nbit_seq_if.slave -- start/operands/controls in,
//                result/result_hi/flags/busy/done out (all registered)
module alu_nbit_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_nbit_seq_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH:0]     partial;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   a_p, b_p, alu_res;
  logic [WIDTH:0]     sum;
  logic               c_msb, ovf, less;
  logic               accept, last;

  logic [WIDTH-1:0]   result_r, result_hi_r;
  logic               carry_r, ovf_r, zero_r, busy_r, done_r;

  // Single-cycle datapath.
  always_comb begin
    a_p     = bus.ainvert ? ~bus.a : bus.a;
    b_p     = bus.binvert ? ~bus.b : bus.b;
    sum     = {1'b0, a_p} + {1'b0, b_p} + (WIDTH+1)'(bus.binvert);
    // Carry into the MSB recovered from the MSB sum bit.
    c_msb   = a_p[WIDTH-1] ^ b_p[WIDTH-1] ^ sum[WIDTH-1];
    ovf     = c_msb ^ sum[WIDTH];
    less    = sum[WIDTH-1] ^ ovf;
    alu_res = '0;
    case (bus.operation)
      2'b00:   alu_res = a_p & b_p;
      2'b01:   alu_res = a_p | b_p;
      2'b10:   alu_res = sum[WIDTH-1:0];
      default: alu_res = {{(WIDTH-1){1'b0}}, less};
    endcase
  end

  // One shift-add step: add into the upper half, then shift {carry, acc} right.
  always_comb begin
    partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step = {partial, acc[WIDTH-1:1]};
  end

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == MUL) && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && bus.mul_mode) state_nxt = MUL;
      MUL:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      result_r    <= '0;
      result_hi_r <= '0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        if (bus.mul_mode) begin
          mcand  <= bus.a;
          mplier <= bus.b;
          acc    <= '0;
          cnt    <= '0;
          busy_r <= 1'b1;
        end else begin
          result_r    <= alu_res;
          result_hi_r <= '0;
          carry_r     <= sum[WIDTH];
          ovf_r       <= ovf;
          zero_r      <= (alu_res == '0);
          done_r      <= 1'b1;
        end
      end else if (state == MUL) begin
        acc    <= acc_step;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          result_r    <= acc_step[WIDTH-1:0];
          result_hi_r <= acc_step[2*WIDTH-1:WIDTH];
          carry_r     <= 1'b0;
          ovf_r       <= |acc_step[2*WIDTH-1:WIDTH];
          zero_r      <= (acc_step == '0);
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
        end
      end
    end
  end

  assign bus.result    = result_r;
  assign bus.result_hi = result_hi_r;
  assign bus.carry_out = carry_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb_alu_nbit_seq: directed vectors for alu_nbit_seq (WIDTH = 8). The driver
// pushes the expected response and its completion cycle into a queue; the
// monitor pops on every done and compares.
module tb_alu_nbit_seq;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] hi;
    logic       c;
    logic       v;
    logic       z;
    int         at;
    string      nm;
  } exp_t;

  exp_t sb[$];

  alu_nbit_seq_if #(.WIDTH(W)) bus ();

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_out"},
            {13'd0, bus.result, bus.result_hi, bus.carry_out, bus.overflow, bus.zero},
            {13'd0, e.r, e.hi, e.c, e.v, e.z});
        chk({e.nm, "_cycle"}, cyc, e.at);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ai,
                       input logic bi, input logic [1:0] op, input logic mm,
                       input logic [7:0] er, input logic [7:0] eh, input logic ec,
                       input logic ev, input logic ez, input string nm);
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.ainvert   = ai;
    bus.binvert   = bi;
    bus.operation = op;
    bus.mul_mode  = mm;
    e.r = er; e.hi = eh; e.c = ec; e.v = ev; e.z = ez; e.nm = nm;
    e.at = cyc + 1 + (mm ? int'(W) : 0);
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] all_out();
    return {15'd0, bus.result, bus.result_hi, bus.carry_out, bus.overflow,
            bus.zero, bus.busy, bus.done};
  endfunction

  initial begin
    // Reset with random inputs and start asserted.
    bus.start     = 1'b1;
    bus.a         = 8'($urandom);
    bus.b         = 8'($urandom);
    bus.ainvert   = 1'($urandom);
    bus.binvert   = 1'($urandom);
    bus.operation = 2'($urandom);
    bus.mul_mode  = 1'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_outputs", all_out(), 32'd0);

    // Add / sub / slt.
    issue(8'h7F, 8'h01, 0, 0, 2'b10, 0, 8'h80, 8'h00, 0, 1, 0, "add_7f_01");
    idle();
    issue(8'hFF, 8'h01, 0, 0, 2'b10, 0, 8'h00, 8'h00, 1, 0, 1, "add_ff_01");
    idle();
    issue(8'h05, 8'h05, 0, 1, 2'b10, 0, 8'h00, 8'h00, 1, 0, 1, "sub_5_5");
    idle();
    issue(8'hFE, 8'h01, 0, 1, 2'b11, 0, 8'h01, 8'h00, 1, 0, 0, "slt_fe_01");
    idle();
    issue(8'h01, 8'hFE, 0, 1, 2'b11, 0, 8'h00, 8'h00, 0, 0, 1, "slt_01_fe");
    idle();

    // Logic ops back-to-back, one result per cycle.
    issue(8'hF0, 8'h3C, 0, 0, 2'b00, 0, 8'h30, 8'h00, 1, 0, 0, "and_f0_3c");
    issue(8'hF0, 8'h3C, 0, 0, 2'b01, 0, 8'hFC, 8'h00, 1, 0, 0, "or_f0_3c");
    issue(8'hF0, 8'h0F, 1, 1, 2'b00, 0, 8'h00, 8'h00, 1, 0, 1, "nor_f0_0f");
    issue(8'h7F, 8'h01, 0, 0, 2'b10, 0, 8'h80, 8'h00, 0, 1, 0, "add_b2b");
    idle();
    repeat (2) @(negedge clk);

    // Multiply with a start pulsed mid-operation (must be ignored).
    issue(8'hFF, 8'hFF, 0, 0, 2'b00, 1, 8'h01, 8'hFE, 0, 1, 0, "mul_ff_ff");
    idle();
    chk("mul_busy_0", 32'(bus.busy), 32'd1);
    for (int i = 1; i < int'(W); i++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_%0d", i), 32'(bus.busy), 32'd1);
      if (i == 3) begin
        bus.start = 1'b1; bus.mul_mode = 1'b0; bus.a = 8'h0F; bus.b = 8'h0F;
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("mul_busy_end", 32'(bus.busy), 32'd0);

    issue(8'h00, 8'h55, 0, 0, 2'b00, 1, 8'h00, 8'h00, 0, 0, 1, "mul_0_55");
    idle();
    repeat (W + 2) @(negedge clk);

    // Abort a multiply with reset.
    issue(8'h12, 8'h34, 0, 0, 2'b00, 1, 8'h00, 8'h00, 0, 0, 0, "mul_aborted");
    idle();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", all_out(), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    chk("abort_no_output", all_out(), 32'd0);

    issue(8'h03, 8'h04, 0, 0, 2'b00, 1, 8'h0C, 8'h00, 0, 0, 0, "mul_3_4");
    idle();

    // Drain the scoreboard within a bounded wait.
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
